// File: rtl/game_sequencer.sv
// Game sequencer for a two-snake game: key edge detection, IDLE/RUN/PAUSE/OVER flow, speed control and step strobes.
// Define GAME_SEQUENCER_DEBOUNCE_EN to put a stable-time filter in front of every key.
module game_sequencer #(
  parameter int unsigned TICK_BASE       = 12500000,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_clear,
  input  logic        key_pause,
  input  logic        key_faster,
  input  logic        key_slower,
  input  logic        stop1,
  input  logic        stop2,
  output logic        step1,
  output logic        step2,
  output logic        clear_pulse,
  output logic [1:0]  state,
  output logic [1:0]  rate,
  output logic [15:0] moves
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_OVER  = 2'b11
  } state_t;

  // Key bit order: 0 clear, 1 pause, 2 faster, 3 slower.
  logic [3:0] w_key_raw;
  logic [3:0] w_key_lvl;
  logic [3:0] r_key_prev;
  logic [3:0] r_key_arm;
  logic [3:0] w_key_ev;

  assign w_key_raw = {key_slower, key_faster, key_pause, key_clear};

`ifdef GAME_SEQUENCER_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  logic [DB_W-1:0] r_db_cnt [4];
  logic [3:0]      r_db_lvl;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_db_lvl <= '0;
      for (int k = 0; k < 4; k++) r_db_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (w_key_raw[k] == r_db_lvl[k]) begin
          r_db_cnt[k] <= '0;
        end else if (r_db_cnt[k] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          r_db_lvl[k] <= w_key_raw[k];
          r_db_cnt[k] <= '0;
        end else begin
          r_db_cnt[k] <= r_db_cnt[k] + 1'b1;
        end
      end
    end
  end

  assign w_key_lvl = r_db_lvl;
`else
  assign w_key_lvl = w_key_raw;
`endif

  // A key only arms once it has been seen released, so a key held through reset stays silent.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_key_prev <= '0;
      r_key_arm  <= '0;
    end else begin
      r_key_prev <= w_key_lvl;
      r_key_arm  <= r_key_arm | (~w_key_raw & ~w_key_lvl);
    end
  end

  assign w_key_ev = w_key_lvl & ~r_key_prev & r_key_arm;

  logic w_clr_ev, w_pause_ev, w_fast_ev, w_slow_ev;
  assign w_clr_ev   = w_key_ev[0];
  assign w_pause_ev = w_key_ev[1];
  assign w_fast_ev  = w_key_ev[2];
  assign w_slow_ev  = w_key_ev[3];

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_rate, w_rate_nxt;
  logic [31:0] r_tick_cnt, w_tick_cnt_nxt;
  logic [31:0] w_period;
  logic        w_tick, w_over_go, w_suppress;
  logic        r_step1, r_step2, r_clr_pulse;
  logic [15:0] r_moves;

  assign w_period   = 32'(TICK_BASE) << r_rate;
  assign w_tick     = (r_state == S_RUN) && (r_tick_cnt == w_period - 32'd1);
  assign w_over_go  = (r_state == S_RUN) && stop1 && stop2;
  assign w_suppress = w_clr_ev || w_over_go;

  always_comb begin
    w_state_nxt = r_state;
    if (w_clr_ev) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_pause_ev) w_state_nxt = S_RUN;
        S_RUN: begin
          if (w_over_go)       w_state_nxt = S_OVER;
          else if (w_pause_ev) w_state_nxt = S_PAUSE;
        end
        S_PAUSE: if (w_pause_ev) w_state_nxt = S_RUN;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_comb begin
    w_rate_nxt = r_rate;
    if (w_fast_ev && !w_slow_ev && r_rate != 2'b00)      w_rate_nxt = r_rate - 2'd1;
    else if (w_slow_ev && !w_fast_ev && r_rate != 2'b11) w_rate_nxt = r_rate + 2'd1;
  end

  // Counter restarts on any speed change so the new period is measured from that moment.
  always_comb begin
    w_tick_cnt_nxt = r_tick_cnt;
    if (w_clr_ev || (w_rate_nxt != r_rate) || r_state == S_IDLE || r_state == S_OVER)
      w_tick_cnt_nxt = 32'd0;
    else if (r_state == S_RUN)
      w_tick_cnt_nxt = w_tick ? 32'd0 : r_tick_cnt + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rate      <= 2'b10;
      r_tick_cnt  <= 32'd0;
      r_moves     <= 16'd0;
      r_step1     <= 1'b0;
      r_step2     <= 1'b0;
      r_clr_pulse <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rate      <= w_rate_nxt;
      r_tick_cnt  <= w_tick_cnt_nxt;
      r_step1     <= w_tick && !stop1 && !w_suppress;
      r_step2     <= w_tick && !stop2 && !w_suppress;
      r_clr_pulse <= w_clr_ev;
      if (w_clr_ev)                          r_moves <= 16'd0;
      else if (w_tick && r_moves != 16'hFFFF) r_moves <= r_moves + 16'd1;
    end
  end

  assign step1       = r_step1;
  assign step2       = r_step2;
  assign clear_pulse = r_clr_pulse;
  assign state       = r_state;
  assign rate        = r_rate;
  assign moves       = r_moves;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer with TICK_BASE=4, DEBOUNCE_CYCLES=3.
// Step strobes are checked against a queue of expected {cycle, step1, step2, moves} entries.
module tb_game_sequencer;

  localparam int TB_TICK = 4;
  localparam int TB_DB   = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_clear, key_pause, key_faster, key_slower;
  logic        stop1, stop2;
  logic        step1, step2, clear_pulse;
  logic [1:0]  state, rate;
  logic [15:0] moves;

  game_sequencer #(.TICK_BASE(TB_TICK), .DEBOUNCE_CYCLES(TB_DB)) dut (
    .clk(clk), .rst(rst),
    .key_clear(key_clear), .key_pause(key_pause),
    .key_faster(key_faster), .key_slower(key_slower),
    .stop1(stop1), .stop2(stop2),
    .step1(step1), .step2(step2), .clear_pulse(clear_pulse),
    .state(state), .rate(rate), .moves(moves)
  );

  // Clock and cycle count (number of rising edges seen so far).
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;
  logic [33:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_step(input int c, input logic s1, input logic s2, input int mv);
    logic [15:0] c16;
    logic [15:0] mv16;
    c16  = c[15:0];
    mv16 = mv[15:0];
    exp_q.push_back({c16, s1, s2, mv16});
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Scoreboard: every step strobe must match the head of the expected queue.
  always @(negedge clk) begin : mon
    logic [33:0] got;
    if (!rst && (step1 !== 1'b0 || step2 !== 1'b0)) begin
      got = {cyc[15:0], step1, step2, moves};
      if (exp_q.size() == 0) check("unexpected_step", {30'd0, got}, 64'd0);
      else                   check("step", {30'd0, got}, {30'd0, exp_q.pop_front()});
    end
  end

  typedef struct {
    logic       fast;
    logic       slow;
    logic [1:0] exp_rate;
  } rate_vec_t;
  rate_vec_t rv[10];

  task automatic apply_rate_row(input int i);
    key_faster = rv[i].fast;
    key_slower = rv[i].slow;
    @(negedge clk);
    check($sformatf("rate_row%0d", i), {62'd0, rate}, {62'd0, rv[i].exp_rate});
    key_faster = 1'b0;
    key_slower = 1'b0;
    @(negedge clk);
  endtask

  int e0, e1, p, r, c, e2, r2;

  initial begin
    rv[0] = '{1'b1, 1'b0, 2'b01};
    rv[1] = '{1'b1, 1'b0, 2'b00};
    rv[2] = '{1'b1, 1'b0, 2'b00};
    rv[3] = '{1'b1, 1'b0, 2'b00};
    rv[4] = '{1'b0, 1'b1, 2'b01};
    rv[5] = '{1'b0, 1'b1, 2'b10};
    rv[6] = '{1'b0, 1'b1, 2'b11};
    rv[7] = '{1'b0, 1'b1, 2'b11};
    rv[8] = '{1'b0, 1'b1, 2'b11};
    rv[9] = '{1'b1, 1'b1, 2'b11};

    rst = 1'b1;
    key_clear = 1'b0; key_pause = 1'b1; key_faster = 1'b0; key_slower = 1'b0;
    stop1 = 1'b0; stop2 = 1'b0;
    wait_cyc(3);
    check("reset_state", {62'd0, state}, 64'd0);
    check("reset_rate", {62'd0, rate}, 64'd2);
    check("reset_moves", {48'd0, moves}, 64'd0);
    check("reset_step1", {63'd0, step1}, 64'd0);
    check("reset_step2", {63'd0, step2}, 64'd0);
    check("reset_clear_pulse", {63'd0, clear_pulse}, 64'd0);

`ifdef GAME_SEQUENCER_DEBOUNCE_EN
    key_pause = 1'b0;
    rst = 1'b0;
    wait_cyc(3);
    key_pause = 1'b1; wait_cyc(2); key_pause = 1'b0; wait_cyc(10);
    check("glitch_ignored", {62'd0, state}, 64'd0);
    key_pause = 1'b1; wait_cyc(5); key_pause = 1'b0; wait_cyc(8);
    check("debounced_single_event", {62'd0, state}, 64'd1);
`else
    // Pause held through reset release must not start the game.
    rst = 1'b0;
    wait_cyc(5);
    check("held_through_reset", {62'd0, state}, 64'd0);
    key_pause = 1'b0;
    wait_cyc(2);

    // Held pause: one event, steps every 16 cycles at rate 10.
    key_pause = 1'b1;
    @(negedge clk);
    e0 = cyc;
    push_step(e0 + 16, 1'b1, 1'b1, 1);
    push_step(e0 + 32, 1'b1, 1'b1, 2);
    push_step(e0 + 48, 1'b1, 1'b1, 3);
    check("pause_to_run", {62'd0, state}, 64'd1);
    wait_cyc(9);
    key_pause = 1'b0;
    check("held_pause_single_event", {62'd0, state}, 64'd1);
    wait_until(e0 + 50);
    check("run_steps_done", 64'(exp_q.size()), 64'd0);

    // Snake 1 stops, then both stop -> OVER; pause ignored there.
    stop1 = 1'b1;
    push_step(e0 + 64, 1'b0, 1'b1, 4);
    wait_until(e0 + 70);
    stop2 = 1'b1;
    @(negedge clk);
    check("run_to_over", {62'd0, state}, 64'd3);
    key_pause = 1'b1; wait_cyc(2); key_pause = 1'b0;
    wait_cyc(40);
    check("over_ignores_pause", {62'd0, state}, 64'd3);
    check("over_moves_hold", {48'd0, moves}, 64'd4);
    check("over_no_steps", 64'(exp_q.size()), 64'd0);
    stop1 = 1'b0; stop2 = 1'b0;

    // Clear from OVER.
    key_clear = 1'b1;
    @(negedge clk);
    check("clear_over_state", {62'd0, state}, 64'd0);
    check("clear_over_pulse", {63'd0, clear_pulse}, 64'd1);
    check("clear_over_moves", {48'd0, moves}, 64'd0);
    @(negedge clk);
    check("clear_over_pulse_end", {63'd0, clear_pulse}, 64'd0);
    key_clear = 1'b0;
    check("clear_keeps_rate", {62'd0, rate}, 64'd2);
    wait_cyc(2);

    // Pause with the counter frozen at 7, resume -> step 9 cycles later.
    key_pause = 1'b1;
    @(negedge clk);
    e1 = cyc;
    key_pause = 1'b0;
    push_step(e1 + 16, 1'b1, 1'b1, 1);
    wait_until(e1 + 22);
    key_pause = 1'b1;
    @(negedge clk);
    p = cyc;
    key_pause = 1'b0;
    check("run_to_pause", {62'd0, state}, 64'd2);
    wait_cyc(20);
    check("pause_no_steps", 64'(exp_q.size()), 64'd0);
    check("pause_holds", {62'd0, state}, 64'd2);
    key_pause = 1'b1;
    @(negedge clk);
    r = cyc;
    key_pause = 1'b0;
    check("pause_to_run_resume", {62'd0, state}, 64'd1);
    push_step(r + 9, 1'b1, 1'b1, 2);

    // Clear and pause together, landing on a tick: no step, back to IDLE.
    wait_until(r + 24);
    key_clear = 1'b1; key_pause = 1'b1;
    @(negedge clk);
    c = cyc;
    key_clear = 1'b0; key_pause = 1'b0;
    check("clear_pause_state", {62'd0, state}, 64'd0);
    check("clear_pause_pulse", {63'd0, clear_pulse}, 64'd1);
    check("clear_pause_moves", {48'd0, moves}, 64'd0);
    check("clear_pause_rate", {62'd0, rate}, 64'd2);
    @(negedge clk);
    check("clear_pause_pulse_end", {63'd0, clear_pulse}, 64'd0);
    wait_cyc(40);
    check("idle_after_clear", {62'd0, state}, 64'd0);
    check("clear_no_steps", 64'(exp_q.size()), 64'd0);

    // Speed table: faster x4 in IDLE, then period 4 in RUN.
    for (int i = 0; i < 4; i++) apply_rate_row(i);
    key_pause = 1'b1;
    @(negedge clk);
    e2 = cyc;
    key_pause = 1'b0;
    push_step(e2 + 4, 1'b1, 1'b1, 1);
    push_step(e2 + 8, 1'b1, 1'b1, 2);
    push_step(e2 + 12, 1'b1, 1'b1, 3);
    wait_until(e2 + 13);
    key_pause = 1'b1;
    @(negedge clk);
    key_pause = 1'b0;
    check("fast_pause_state", {62'd0, state}, 64'd2);
    wait_cyc(1);

    // Slower x5 plus a simultaneous press, then period 32 after resume.
    for (int i = 4; i < 10; i++) apply_rate_row(i);
    key_pause = 1'b1;
    @(negedge clk);
    r2 = cyc;
    key_pause = 1'b0;
    push_step(r2 + 32, 1'b1, 1'b1, 4);
    push_step(r2 + 64, 1'b1, 1'b1, 5);
    wait_until(r2 + 66);
    check("slow_steps_done", 64'(exp_q.size()), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 SHALL have parameter TICK_BASE, default 12500000, clk cycles per step at rate 00 (4 Hz at 50 MHz).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 500000, key stable-time in clk cycles (used only per REQ-027).
REQ-003 SHALL have port clk, input, 1, 50 MHz system clock.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port key_clear, input, 1, clear-game key level, 1 = pressed.
REQ-006 SHALL have port key_pause, input, 1, start/pause/resume key level.
REQ-007 SHALL have port key_faster, input, 1, speed-up key level.
REQ-008 SHALL have port key_slower, input, 1, slow-down key level.
REQ-009 SHALL have port stop1, input, 1, snake 1 dead or collided (level).
REQ-010 SHALL have port stop2, input, 1, snake 2 dead or collided (level).
REQ-011 SHALL have port step1, output, 1, one-cycle move strobe for snake 1.
REQ-012 SHALL have port step2, output, 1, one-cycle move strobe for snake 2.
REQ-013 SHALL have port clear_pulse, output, 1, one-cycle game-clear strobe.
REQ-014 SHALL have port state, output, 2, game state: 00 IDLE, 01 RUN, 10 PAUSE, 11 OVER.
REQ-015 SHALL have port rate, output, 2, speed: 00 4 Hz, 01 2 Hz, 10 1 Hz, 11 0.5 Hz.
REQ-016 SHALL have port moves, output, 16, ticks issued since last clear, saturating at 16'hFFFF.

Function
REQ-017 SHALL register each key and act only on a rising edge (prev 0, current 1); a held key SHALL produce one event.
REQ-018 SHALL implement the state transitions IDLE->RUN, RUN->PAUSE and PAUSE->RUN, each on a pause event.
REQ-019 SHALL move RUN->OVER in the cycle where stop1 && stop2 are both 1; OVER SHALL ignore pause events.
REQ-020 SHALL, on a clear event in any state, go to IDLE, assert clear_pulse for exactly one cycle, zero moves and zero the tick counter; clear SHALL take priority over a simultaneous pause event or stop condition.
REQ-021 SHALL, on a faster event, decrement rate saturating at 00, and on a slower event increment rate saturating at 11; a simultaneous faster and slower event SHALL leave rate unchanged; rate SHALL be retained across clear.
REQ-022 SHALL implement the step period as TICK_BASE << rate cycles, counted by a 32-bit tick counter that advances only in RUN, holds its value in PAUSE, and is zeroed in IDLE and OVER and on any rate change.
REQ-023 SHALL, when the counter reaches period-1 in RUN, wrap it to 0 and raise an internal tick for that cycle.
REQ-024 SHALL register step1 as tick && !stop1 and step2 as tick && !stop2, giving one-cycle latency from the tick; moves SHALL increment on each tick.
REQ-025 SHALL suppress both steps when a tick coincides with a RUN->OVER transition or with a clear event.

Reset
REQ-026 SHALL, while rst=1 at a clk edge, set state=IDLE, rate=10, moves=0, tick counter=0, step1=step2=clear_pulse=0, and all key history registers to 0; a key held through reset release SHALL NOT produce an event.

Configuration
REQ-027 SHALL, with GAME_SEQUENCER_DEBOUNCE_EN defined, pass each key through a per-key counter that updates the filtered level only after DEBOUNCE_CYCLES consecutive equal samples; without the macro, keys SHALL feed edge detection directly with one register stage.

Verification (TICK_BASE=4, DEBOUNCE_CYCLES=3, macro undefined unless stated)
REQ-028 SHALL cover: reset, pause held 10 cycles -> state=01, single event; rate=10 -> step1/step2 pulse every 16 cycles, moves counts 1,2,3.
REQ-029 SHALL cover: in RUN, stop1=1 -> only step2 pulses; then stop2=1 -> state=11 next cycle, no further steps, pause ignored.
REQ-030 SHALL cover: faster pressed 4 times from rate 10 -> rate 01, 00, 00, 00 with period 4 cycles; slower 5 times -> saturates at 11 with period 32.
REQ-031 SHALL cover: pause at counter=7 in RUN -> PAUSE, counter holds 7; resume -> next step 9 cycles later.
REQ-032 SHALL cover: clear and pause events in the same cycle during RUN -> state=00, clear_pulse one cycle, moves=0, rate unchanged.
REQ-033 SHALL cover, with the macro defined: 2-cycle glitch on key_pause -> no event; 5-cycle press -> exactly one event.
